// File: rtl/rst_cipher_pkg.sv
// Shared constants, state encoding and helper functions for the rst cipher link.
package rst_cipher_pkg;

  localparam int unsigned KEY_LEN = 12;
  localparam int unsigned TBL_DIM = 6;

  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_UA  = 8'h41;
  localparam logic [7:0] CH_UZ  = 8'h5A;
  localparam logic [7:0] CH_LA  = 8'h61;
  localparam logic [7:0] CH_LZ  = 8'h7A;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;

  typedef enum logic {
    NO_KEY,
    RUN
  } dec_state_t;

  function automatic logic is_alnum(input logic [7:0] c);
    return ((c >= CH_0)  && (c <= CH_9))  ||
           ((c >= CH_UA) && (c <= CH_UZ)) ||
           ((c >= CH_LA) && (c <= CH_LZ));
  endfunction

  function automatic logic [7:0] idx_to_char(input logic [5:0] idx);
    if (idx < 6'd26) return CH_LA + {2'b00, idx};
    else             return CH_0 + ({2'b00, idx} - 8'd26);
  endfunction

  // Rows take key[11],key[1],key[9],key[3],key[7],key[5]; columns the neighbours one below.
  function automatic logic [3:0] key_row_sel(input int unsigned pos);
    if (pos % 2 == 0) return 4'(11 - pos);
    else              return 4'(pos);
  endfunction

  function automatic logic [3:0] key_col_sel(input int unsigned pos);
    if (pos % 2 == 0) return 4'(10 - pos);
    else              return 4'(pos - 1);
  endfunction

endpackage

// File: rtl/rst_label_lookup.sv
// Six-entry label CAM: reports whether query matches a label and at which position.
module rst_label_lookup
  import rst_cipher_pkg::*;
(
  input  logic [5:0][7:0] labels,
  input  logic [7:0]      query,
  output logic            hit,
  output logic [2:0]      index
);

  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int unsigned p = 0; p < TBL_DIM; p++) begin
      if (!hit && (labels[p] == query)) begin
        hit   = 1'b1;
        index = 3'(p);
      end
    end
  end

endmodule

// File: rtl/rst_decipher.sv
// Receive-side decoder: maps 2-char row/column tokens back to plaintext using a rotating 6x6 table.
module rst_decipher
  import rst_cipher_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0][7:0] key,
  input  logic             ctxt_valid,
  input  logic [15:0]      ctxt_str,
  output logic [7:0]       ptxt_char,
  output logic             ptxt_ready,
  output logic             err_invalid_key,
  output logic             err_invalid_ctxt_char
);

  dec_state_t      state;
  logic [2:0]      off;
  logic [5:0][7:0] row_tbl, col_tbl;
  logic [5:0][7:0] key_rows, key_cols;
  logic [5:0][7:0] row_lbl, col_lbl;
  logic            key_ok;
  logic            row_hit, col_hit;
  logic [2:0]      row_pos, col_pos;
  logic [3:0]      row_sum, col_sum;
  logic [2:0]      row_i, col_j;
  logic [5:0]      idx;

  always_comb begin
    key_ok = 1'b1;
    for (int unsigned a = 0; a < KEY_LEN; a++) begin
      if (!is_alnum(key[a])) key_ok = 1'b0;
      for (int unsigned b = a + 1; b < KEY_LEN; b++) begin
        if (key[a] == key[b]) key_ok = 1'b0;
      end
    end
  end

  always_comb begin
    key_rows = '0;
    key_cols = '0;
    for (int unsigned p = 0; p < TBL_DIM; p++) begin
      key_rows[p] = key[key_row_sel(p)];
      key_cols[p] = key[key_col_sel(p)];
    end
  end

  // Install beat decodes straight from the key; afterwards from the stored table.
  assign row_lbl = (state == NO_KEY) ? key_rows : row_tbl;
  assign col_lbl = (state == NO_KEY) ? key_cols : col_tbl;

  rst_label_lookup u_row_cam (
    .labels (row_lbl),
    .query  (ctxt_str[15:8]),
    .hit    (row_hit),
    .index  (row_pos)
  );

  rst_label_lookup u_col_cam (
    .labels (col_lbl),
    .query  (ctxt_str[7:0]),
    .hit    (col_hit),
    .index  (col_pos)
  );

  // Table is kept un-rotated; a right rotation by off moves installed slot p to (p+off) mod 6.
  always_comb begin
    row_sum = {1'b0, row_pos} + {1'b0, off};
    col_sum = {1'b0, col_pos} + {1'b0, off};
    row_i   = (row_sum >= 4'd6) ? 3'(row_sum - 4'd6) : row_sum[2:0];
    col_j   = (col_sum >= 4'd6) ? 3'(col_sum - 4'd6) : col_sum[2:0];
    idx     = ({3'b000, row_i} * 6'd6) + {3'b000, col_j};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= NO_KEY;
      off                   <= '0;
      row_tbl               <= '0;
      col_tbl               <= '0;
      ptxt_char             <= '0;
      ptxt_ready            <= 1'b0;
      err_invalid_key       <= 1'b0;
      err_invalid_ctxt_char <= 1'b0;
    end else begin
      ptxt_ready            <= 1'b0;
      err_invalid_key       <= 1'b0;
      err_invalid_ctxt_char <= 1'b0;
      if (ctxt_valid) begin
        if ((state == NO_KEY) && !key_ok) begin
          err_invalid_key <= 1'b1;
        end else begin
          if (state == NO_KEY) begin
            row_tbl <= key_rows;
            col_tbl <= key_cols;
            state   <= RUN;
          end
          if (row_hit && col_hit) begin
            ptxt_char  <= idx_to_char(idx);
            ptxt_ready <= 1'b1;
            off        <= (off == 3'd5) ? 3'd0 : off + 3'd1;
          end else begin
            ptxt_char             <= CH_NUL;
            err_invalid_ctxt_char <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rst_decipher.sv
// Scoreboard bench for rst_decipher: stimulus pushes expected results, a monitor pops and checks.
module tb_rst_decipher;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [11:0][7:0] key = '0;
  logic             ctxt_valid = 1'b0;
  logic [15:0]      ctxt_str = '0;
  logic [7:0]       ptxt_char;
  logic             ptxt_ready;
  logic             err_invalid_key;
  logic             err_invalid_ctxt_char;

  typedef struct {
    logic       ek;
    logic       ec;
    logic [7:0] ch;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [95:0] KEY_GOOD = "ABCDEFGHIJKL";
  localparam logic [95:0] KEY_DUP  = "ABCDEFGHIJKA";
  localparam logic [95:0] KEY_SYM  = "ABCDE?GHIJKL";

  rst_decipher dut (
    .clk                   (clk),
    .rst                   (rst),
    .key                   (key),
    .ctxt_valid            (ctxt_valid),
    .ctxt_str              (ctxt_str),
    .ptxt_char             (ptxt_char),
    .ptxt_ready            (ptxt_ready),
    .err_invalid_key       (err_invalid_key),
    .err_invalid_ctxt_char (err_invalid_ctxt_char)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic beat(input logic [95:0] k, input logic [15:0] c,
                      input logic ek, input logic ec, input logic [7:0] ch);
    exp_t e;
    e.ek = ek; e.ec = ec; e.ch = ch;
    exp_q.push_back(e);
    @(posedge clk); #1;
    key        = k;
    ctxt_str   = c;
    ctxt_valid = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    ctxt_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Independent encoder reference: installed table rows AKCIEG, columns BLDJFH.
  function automatic logic [15:0] encode(input logic [7:0] c, input int k);
    logic [7:0] rows [6];
    logic [7:0] cols [6];
    logic [7:0] lc;
    int idx;
    int pr;
    int pc;
    rows = '{"A", "K", "C", "I", "E", "G"};
    cols = '{"B", "L", "D", "J", "F", "H"};
    lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    idx = (lc >= "a") ? int'(lc - "a") : int'(lc - "0") + 26;
    pr = idx / 6;
    pc = idx % 6;
    return {rows[(pr + 6 - k) % 6], cols[(pc + 6 - k) % 6]};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (ptxt_ready || err_invalid_key || err_invalid_ctxt_char)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {29'd0, ptxt_ready, err_invalid_key, err_invalid_ctxt_char}, 0);
        end else begin
          e = exp_q.pop_front();
          check("err_invalid_key", err_invalid_key, e.ek);
          check("err_invalid_ctxt_char", err_invalid_ctxt_char, e.ec);
          check("ptxt_ready", ptxt_ready, !(e.ek || e.ec));
          if (!e.ek) check("ptxt_char", ptxt_char, e.ch);
        end
      end else if (!rst && exp_q.size() != 0 && !ctxt_valid && !ptxt_ready) begin
        // A beat was issued but produced no output flag at all.
        if (exp_q.size() > 8) check("output_missing", exp_q.size(), 0);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] c;
    logic [7:0] lc;
    int k;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ptxt_char", ptxt_char, 0);
    check("reset_ptxt_ready", ptxt_ready, 0);
    check("reset_err_key", err_invalid_key, 0);
    check("reset_err_ctxt", err_invalid_ctxt_char, 0);
    rst = 1'b0;

    // hello
    beat(KEY_GOOD, "KL", 0, 0, "h");
    beat(KEY_GOOD, "GJ", 0, 0, "e");
    beat(KEY_GOOD, "GJ", 0, 0, "l");
    beat(KEY_GOOD, "ED", 0, 0, "l");
    beat(KEY_GOOD, "EF", 0, 0, "o");
    idle();
    drain();
    repeat (2) @(posedge clk);
    #1 check("ptxt_char_hold", ptxt_char, "o");
    check("idle_ready_low", ptxt_ready, 0);

    // repeated token decodes differently once rotated
    do_reset();
    beat(KEY_GOOD, "KL", 0, 0, "h");
    beat(KEY_GOOD, "KL", 0, 0, "o");
    idle();
    drain();

    // digit path
    do_reset();
    beat(KEY_GOOD, "ED", 0, 0, "0");
    idle();
    drain();

    // undecodable token on install beat: table installs, no rotation
    do_reset();
    beat(KEY_GOOD, "ZZ", 0, 1, 8'h00);
    beat(KEY_GOOD, "KL", 0, 0, "h");
    idle();
    drain();

    // rejected keys, then a good key
    do_reset();
    beat(KEY_DUP, "KL", 1, 0, 8'h00);
    beat(KEY_SYM, "KL", 1, 0, 8'h00);
    beat(KEY_GOOD, "KL", 0, 0, "h");
    beat(KEY_DUP, "KL", 0, 0, "o");
    idle();
    drain();

    // offset wrap: KL cycles through h o v 2 9 a, then back to h
    do_reset();
    beat(KEY_GOOD, "KL", 0, 0, "h");
    beat(KEY_GOOD, "KL", 0, 0, "o");
    beat(KEY_GOOD, "KL", 0, 0, "v");
    beat(KEY_GOOD, "KL", 0, 0, "2");
    beat(KEY_GOOD, "KL", 0, 0, "9");
    beat(KEY_GOOD, "KL", 0, 0, "a");
    beat(KEY_GOOD, "KL", 0, 0, "h");
    idle();
    drain();

    // asynchronous reset mid-stream
    do_reset();
    beat(KEY_GOOD, "KL", 0, 0, "h");
    idle();
    #6 rst = 1'b1;
    #1;
    check("async_rst_ready", ptxt_ready, 0);
    check("async_rst_char", ptxt_char, 0);
    #2 rst = 1'b0;
    drain();
    beat(KEY_GOOD, "KL", 0, 0, "h");
    idle();
    drain();

    // loopback through the reference encoder
    do_reset();
    k = 0;
    for (int i = 0; i < 62; i++) begin
      if (i < 26)      c = 8'("A" + i);
      else if (i < 52) c = 8'("a" + (i - 26));
      else             c = 8'("0" + (i - 52));
      lc = (i < 26) ? c + 8'd32 : c;
      beat(KEY_GOOD, encode(c, k), 0, 0, lc);
      k = (k + 1) % 6;
    end
    idle();
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
